// File: rtl/uart_temp_rx.sv
// Purpose: 8N1 UART receiver plus ASCII "+DDD.FF\r\n" line parser producing a signed x100 temperature.
// Latency: byte strobe 1 clk after the stop-bit sample; valid/temp_x100 1 clk after that (2 clk total).
// Backpressure: none; the line rate bounds input, every byte is consumed as it completes.
module uart_temp_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic signed [31:0] temp_x100,
  output logic               valid,
  output logic               frame_err,
  output logic               parse_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_st_t;
  typedef enum logic [3:0] {P_SIGN, P_D0, P_D1, P_D2, P_DOT, P_F0, P_F1, P_CR, P_LF} parse_st_t;

  // ---------------- synchronizer ----------------
  logic rx_meta, rx_s;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------- byte FSM ----------------
  byte_st_t         b_st_q, b_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             byte_vld_q, byte_vld_d;
  logic             ferr_d;

  // Byte FSM state, counter, shift register and the registered byte/frame-error strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_st_q     <= B_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      byte_vld_q <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      b_st_q     <= b_st_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      byte_vld_q <= byte_vld_d;
      frame_err  <= ferr_d;
    end
  end

  // Byte FSM next state: mid-start resample, then one sample per bit time, LSB first.
  always_comb begin
    b_st_d     = b_st_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    byte_vld_d = 1'b0;
    ferr_d     = 1'b0;
    case (b_st_q)
      B_IDLE: begin
        if (!rx_s) begin
          cnt_d  = '0;
          b_st_d = B_START;
        end
      end
      B_START: begin
        if (cnt_q == CNT_HALF) begin
          if (rx_s) begin
            b_st_d = B_IDLE;              // glitch shorter than half a bit
          end else begin
            cnt_d  = '0;
            idx_d  = '0;
            b_st_d = B_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      B_DATA: begin
        if (cnt_q == CNT_LAST) begin
          sh_d[idx_q] = rx_s;
          cnt_d       = '0;
          if (idx_q == 3'd7) b_st_d = B_STOP;
          else               idx_d  = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      B_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_s) byte_vld_d = 1'b1;
          else      ferr_d     = 1'b1;
          cnt_d  = '0;
          b_st_d = B_IDLE;                // back to IDLE now so an immediate start edge is caught
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: b_st_d = B_IDLE;
    endcase
  end

  // ---------------- line parser ----------------
  parse_st_t          pst_q, pst_d;
  logic               neg_q, neg_d;
  logic [16:0]        acc_q, acc_d;
  logic signed [31:0] temp_d;
  logic               valid_d, perr_d;

  logic [7:0]  byte_dat;
  logic        is_sign, is_digit;
  logic [16:0] acc_next;

  assign byte_dat = sh_q;                 // shift register is stable while byte_vld_q is high
  assign is_sign  = (byte_dat == CH_PLUS) || (byte_dat == CH_MINUS);
  assign is_digit = (byte_dat >= 8'h30) && (byte_dat <= 8'h39);
  assign acc_next = (acc_q * 17'd10) + {13'd0, byte_dat[3:0]};

  // Parser state, accumulator and the registered result/strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pst_q     <= P_SIGN;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      temp_x100 <= '0;
      valid     <= 1'b0;
      parse_err <= 1'b0;
    end else begin
      pst_q     <= pst_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      temp_x100 <= temp_d;
      valid     <= valid_d;
      parse_err <= perr_d;
    end
  end

  // Parser next state: a sign always (re)starts a line; anything unexpected mid-line aborts it.
  always_comb begin
    pst_d   = pst_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    temp_d  = temp_x100;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    if (frame_err) begin
      pst_d = P_SIGN;                     // a corrupted byte invalidates the line silently
    end else if (byte_vld_q) begin
      if (is_sign) begin
        perr_d = (pst_q != P_SIGN);
        neg_d  = (byte_dat == CH_MINUS);
        acc_d  = '0;
        pst_d  = P_D0;
      end else begin
        case (pst_q)
          P_SIGN: begin
            // noise between lines is dropped without complaint
          end
          P_D0, P_D1, P_D2, P_F0, P_F1: begin
            if (is_digit) begin
              acc_d = acc_next;
              case (pst_q)
                P_D0:    pst_d = P_D1;
                P_D1:    pst_d = P_D2;
                P_D2:    pst_d = P_DOT;
                P_F0:    pst_d = P_F1;
                default: pst_d = P_CR;
              endcase
            end else begin
              perr_d = 1'b1;
              pst_d  = P_SIGN;
            end
          end
          P_DOT: begin
            if (byte_dat == CH_DOT) pst_d = P_F0;
            else begin perr_d = 1'b1; pst_d = P_SIGN; end
          end
          P_CR: begin
            if (byte_dat == CH_CR) pst_d = P_LF;
            else begin perr_d = 1'b1; pst_d = P_SIGN; end
          end
          P_LF: begin
            if (byte_dat == CH_LF) begin
              temp_d  = neg_q ? (32'sd0 - $signed({15'd0, acc_q})) : $signed({15'd0, acc_q});
              valid_d = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
            pst_d = P_SIGN;
          end
          default: pst_d = P_SIGN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_temp_rx.sv
// Directed bench for uart_temp_rx at BAUD_DIV=10: line parsing, errors, false start, mid-frame reset.
// Result latency is checked against the start of the LF byte.
// Stimulus is a bit-banged rx line; outputs are sampled on the falling edge.
module tb_uart_temp_rx;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               rx  = 1'b1;
  logic signed [31:0] temp_x100;
  logic               valid, frame_err, parse_err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int byte_start = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_multi = 0, valid_cyc = 0;
  logic signed [31:0] last_val = 0;

  uart_temp_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .temp_x100(temp_x100), .valid(valid), .frame_err(frame_err), .parse_err(parse_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts every cycle each strobe is high.
  always @(negedge clk) begin
    if (valid) begin n_valid++; last_val = temp_x100; valid_cyc = cyc; end
    if (frame_err) n_ferr++;
    if (parse_err) n_perr++;
    if (int'(valid) + int'(frame_err) + int'(parse_err) > 1) n_multi++;
  end

  task automatic clear_counts();
    n_valid = 0; n_ferr = 0; n_perr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (j == 0) byte_start = cyc;
      rx = frame[j];
      repeat (9) @(posedge clk);
    end
  endtask

  task automatic send_line(input string s, input bit crlf);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    if (crlf) begin
      send_byte(8'h0D, 1'b1);
      send_byte(8'h0A, 1'b1);
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (temp_x100 !== 32'sd0) begin tests_failed++; $display("FAIL reset_temp: got %0d want 0", temp_x100); end
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests_run++; if (parse_err !== 1'b0) begin tests_failed++; $display("FAIL reset_parse_err: got %b want 0", parse_err); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic();
    clear_counts();
    send_line("+025.37", 1'b1);
    tests_run++; if (n_valid != 1) begin tests_failed++; $display("FAIL basic_valid_count: got %0d want 1", n_valid); end
    tests_run++; if (temp_x100 !== 32'sd2537) begin tests_failed++; $display("FAIL basic_value: got %0d want 2537", temp_x100); end
    tests_run++; if (valid_cyc != byte_start + 99) begin tests_failed++; $display("FAIL basic_latency: got cycle %0d want %0d", valid_cyc, byte_start + 99); end
    tests_run++; if (n_perr + n_ferr != 0) begin tests_failed++; $display("FAIL basic_errors: got %0d want 0", n_perr + n_ferr); end
  endtask

  task automatic test_neg_and_max();
    clear_counts();
    send_line("-012.50", 1'b1);
    tests_run++; if (n_valid != 1) begin tests_failed++; $display("FAIL neg_valid_count: got %0d want 1", n_valid); end
    tests_run++; if (temp_x100 !== 32'hFFFFFB1E) begin tests_failed++; $display("FAIL neg_value: got %h want fffffb1e", temp_x100); end
    clear_counts();
    send_line("+999.99", 1'b1);
    tests_run++; if (n_valid != 1 || last_val !== 32'sd99999) begin tests_failed++; $display("FAIL max_value: got %0d (%0d pulses) want 99999 (1 pulse)", last_val, n_valid); end
    tests_run++; if (n_perr + n_ferr != 0) begin tests_failed++; $display("FAIL max_errors: got %0d want 0", n_perr + n_ferr); end
  endtask

  task automatic test_parse_err();
    clear_counts();
    send_line("+02A.37", 1'b1);
    tests_run++; if (n_perr != 1) begin tests_failed++; $display("FAIL perr_count: got %0d want 1", n_perr); end
    tests_run++; if (n_valid != 0) begin tests_failed++; $display("FAIL perr_no_valid: got %0d want 0", n_valid); end
    tests_run++; if (temp_x100 !== 32'sd99999) begin tests_failed++; $display("FAIL perr_hold: got %0d want 99999", temp_x100); end
    clear_counts();
    send_line("+010.00", 1'b1);
    tests_run++; if (n_valid != 1 || temp_x100 !== 32'sd1000) begin tests_failed++; $display("FAIL perr_recover: got %0d (%0d pulses) want 1000 (1 pulse)", temp_x100, n_valid); end
    tests_run++; if (n_perr != 0) begin tests_failed++; $display("FAIL perr_recover_err: got %0d want 0", n_perr); end
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_line("+01", 1'b0);
    send_byte(8'h2B, 1'b0);
    @(posedge clk); #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    tests_run++; if (n_ferr != 1) begin tests_failed++; $display("FAIL ferr_count: got %0d want 1", n_ferr); end
    tests_run++; if (n_perr != 0 || n_valid != 0) begin tests_failed++; $display("FAIL ferr_other: got perr %0d valid %0d want 0 0", n_perr, n_valid); end
    clear_counts();
    send_line("-001.01", 1'b1);
    tests_run++; if (n_valid != 1 || temp_x100 !== -32'sd101) begin tests_failed++; $display("FAIL ferr_recover: got %0d (%0d pulses) want -101 (1 pulse)", temp_x100, n_valid); end
    tests_run++; if (n_perr != 0) begin tests_failed++; $display("FAIL ferr_recover_err: got %0d want 0", n_perr); end
  endtask

  task automatic test_neg_zero();
    clear_counts();
    send_line("-000.00", 1'b1);
    tests_run++; if (n_valid != 1 || temp_x100 !== 32'sd0) begin tests_failed++; $display("FAIL negzero: got %0d (%0d pulses) want 0 (1 pulse)", temp_x100, n_valid); end
  endtask

  task automatic test_false_start();
    clear_counts();
    @(posedge clk); #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    tests_run++; if (n_valid + n_ferr + n_perr != 0) begin tests_failed++; $display("FAIL false_start_pulses: got %0d want 0", n_valid + n_ferr + n_perr); end
    send_line("+000.05", 1'b1);
    tests_run++; if (n_valid != 1 || temp_x100 !== 32'sd5) begin tests_failed++; $display("FAIL false_start_recover: got %0d (%0d pulses) want 5 (1 pulse)", temp_x100, n_valid); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] frame;
    clear_counts();
    send_line("+025", 1'b0);
    frame = {1'b1, 8'h2E, 1'b0};
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1 rx = frame[j];
      repeat (9) @(posedge clk);
    end
    @(posedge clk); #1 rx = frame[5];
    repeat (4) @(posedge clk);
    #1 rst = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (temp_x100 !== 32'sd0) begin tests_failed++; $display("FAIL midreset_temp: got %0d want 0", temp_x100); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    tests_run++; if (n_valid + n_ferr + n_perr != 0) begin tests_failed++; $display("FAIL midreset_pulses: got %0d want 0", n_valid + n_ferr + n_perr); end
    send_line("+030.00", 1'b1);
    tests_run++; if (n_valid != 1 || temp_x100 !== 32'sd3000) begin tests_failed++; $display("FAIL midreset_recover: got %0d (%0d pulses) want 3000 (1 pulse)", temp_x100, n_valid); end
    tests_run++; if (n_perr + n_ferr != 0) begin tests_failed++; $display("FAIL midreset_errors: got %0d want 0", n_perr + n_ferr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_and_max();
    test_parse_err();
    test_frame_err();
    test_neg_zero();
    test_false_start();
    test_reset_mid();
    tests_run++; if (n_multi != 0) begin tests_failed++; $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", n_multi); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_temp_rx.md
Name: uart_temp_rx

Overview:
- UART receiver, 8N1, plus an ASCII line parser for a temperature setpoint sent from the host PC.
- Accepts exactly the line format the board's temperature transmitter emits: sign, three integer digits, '.', two fraction digits, CR, LF (e.g. "+025.37\r\n").
- Converts the line to a signed hundredths-of-a-degree value and delivers it to the alarm/threshold logic as a one-cycle strobe.
- Sits between the board rx pin and the threshold register.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate. BAUD_DIV = CLK_FREQ/BAUD, integer division. Baud counter width must hold BAUD_DIV-1 (14 bits at defaults).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- rx  in  1  serial input, idle high; asynchronous to clk.
- temp_x100  out  32 signed  last successfully parsed value, degrees x100.
- valid  out  1  one-cycle pulse: temp_x100 was updated this cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parse_err  out  1  one-cycle pulse: unexpected character in a line.

Behaviour:
- Reset values: temp_x100=0, valid=0, frame_err=0, parse_err=0. Reset also clears the synchronizer to 1, both FSMs to IDLE/WAIT_SIGN, and the accumulator to 0.
- Reset mid-frame aborts everything with no pulses. The first start bit after reset release is received normally.
- rx passes through a 2-flop synchronizer (reset to 1). All decisions use the synchronized value rx_s.
- Byte FSM, with one counter cnt:
  - IDLE: on rx_s==0, load cnt=0 and go to START.
  - START: when cnt reaches BAUD_DIV/2-1, resample. If rx_s==1 it is a false start: return to IDLE, no pulse. Otherwise cnt=0, bit index=0, go to DATA.
  - DATA: every BAUD_DIV cycles sample rx_s into bit[index], LSB first. After bit 7 go to STOP.
  - STOP: after BAUD_DIV cycles sample rx_s.
    - 1: byte_valid pulse with the data byte.
    - 0: frame_err pulse; byte discarded; parser forced to WAIT_SIGN with no parse_err.
    - Either way, return to IDLE in the same cycle, so a start edge arriving immediately afterwards is caught.
- Parser FSM acts only on byte_valid. Expected sequence: WAIT_SIGN, D0, D1, D2, DOT, F0, F1, CR, LF.
  - WAIT_SIGN: '+' or '-' sets neg accordingly, clears acc, and goes to D0. Any other byte is ignored silently (no parse_err), which allows resync on line noise.
  - Digit states: the byte must be '0'..'9'. acc <= acc*10 + (byte-8'h30). acc is 17-bit unsigned; maximum 99999.
  - DOT requires '.'. CR requires 8'h0D. LF requires 8'h0A.
  - Any mismatch in D0..LF: parse_err pulse, then go to WAIT_SIGN.
  - Exception: '+' or '-' received in D0..LF also raises parse_err, but is then taken as a new sign (go to D0, acc cleared).
  - On LF accepted: temp_x100 <= neg ? -acc : acc (sign-extended to 32 bits), valid=1, return to WAIT_SIGN.
- Latency: byte_valid is registered one cycle after the stop-bit sample. valid/temp_x100 update one cycle after byte_valid, i.e. 2 clk after the LF stop-bit sample.
- "-000.00" yields temp_x100=0 with valid pulsed.
- temp_x100 holds its value between valid pulses and is unchanged by any error.
- At most one of valid/frame_err/parse_err is high in any cycle.
- No receive FIFO and no overrun detection; the next byte cannot complete sooner than 10 bit times.

Test Plan:
- The bench may override CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10).
- Send "+025.37\r\n" -> exactly one valid pulse, temp_x100=2537, 2 clk after the LF stop sample; no error pulses.
- Send "-012.50\r\n" then "+999.99\r\n" -> valid pulses with -1250 (32'hFFFFFB1E), then 99999.
- Send "+02A.37\r\n" then "+010.00\r\n" -> parse_err on 'A', no valid for the first line; then valid with 1000. The stray bytes ".37\r\n" produce no extra pulses.
- Send byte '+' with stop bit driven 0, then "-001.01\r\n" -> frame_err pulse, no parse_err; then valid with -101.
- Drive rx low for 3 clk (under half a bit) -> no byte, no pulses. Then send "+000.05\r\n" -> valid with 5.
- Assert rst (low) during bit 4 of the '.' byte of "+025.37\r\n", release it, then send "+030.00\r\n" -> no pulses during the aborted line, temp_x100=0 after reset, then valid with 3000.
